cfg_shift_ctrl: RTL and testbench
=================================

Name: cfg_shift_ctrl

Overview:
- Sequencer for the DUT configuration chain (config_clk, config_in, config_load, config_out).
- Streams up to CFG_BITS bits from a source word buffer into the chip, capturing config_out readback into a readback word buffer, then optionally pulses config_load.
- Sits in fw_top between the AXI register/buffer file and the DUT-side FPGA pins; software starts it and polls busy/done.

Parameters:
- CFG_BITS, 1024, maximum chain length in bits
- WORD_W, 32, width of source/readback buffer words
- ADDR_W, 5, buffer word-address width (2**ADDR_W*WORD_W >= CFG_BITS)

Ports:
- S_AXI_ACLK  in  1  sole clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a transfer when idle
- abort  in  1  level/pulse; terminates any transfer
- clk_div  in  8  config_clk half-period in ACLK cycles
- n_bits  in  16  bits to shift this transfer
- load_en  in  1  pulse config_load after shifting
- src_addr  out  ADDR_W  source buffer read address
- src_data  in  WORD_W  source word, valid 1 cycle after src_addr
- rb_we  out  1  readback write strobe
- rb_addr  out  ADDR_W  readback write address
- rb_data  out  WORD_W  readback word
- config_clk  out  1  DUT config shift clock
- config_in  out  1  DUT config serial data
- config_load  out  1  DUT config latch strobe
- config_out  in  1  DUT serial readback, asynchronous
- busy  out  1  high from accepted start until done/abort
- done  out  1  one-cycle completion pulse
- aborted  out  1  sticky; set by abort while busy, cleared by next accepted start
- bit_cnt  out  16  bits shifted so far in current/last transfer

Behaviour:
- Reset: all outputs 0; FSM IDLE; synchronizer flops 0.
- H = max(clk_div, 4); the floor covers the 2-flop config_out synchronizer. Latched at start; clk_div/n_bits/load_en changes mid-transfer ignored.
- n_bits latched as min(n_bits, CFG_BITS). 0 means: busy for 1 cycle, then done; no pulses, no rb writes.
- start while busy: ignored.
- Bit ordering: stream bit i = src word i/WORD_W, bit i%WORD_W, LSB first. Readback uses identical packing.
- States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, FLUSH, LOAD_SETUP, LOAD, DONE.
- IDLE -> FETCH on start (n_bits>0).
- FETCH: 2 cycles.
  - Cycle 1 drives src_addr.
  - Cycle 2 registers src_data into the shift word.
  - config_clk held low throughout; this stretches the low phase, which the DUT tolerates.
- SHIFT_LO: H cycles; config_clk=0; config_in = current bit from first cycle.
- SHIFT_HI: H cycles; config_clk=1 (DUT shifts on rising edge).
  - Last cycle: capture synchronized config_out into readback word bit position.
  - Increment bit_cnt.
- After SHIFT_HI:
  - bit_cnt==n_bits -> FLUSH.
  - Word boundary reached -> write full readback word (rb_we 1 cycle, rb_addr = word index), then FETCH next word.
  - Otherwise -> SHIFT_LO.
- FLUSH: 1 cycle; writes final partial readback word, zero-padded above the last bit; config_clk=0, config_in=0.
- FLUSH exit: LOAD_SETUP if load_en, else DONE.
- LOAD_SETUP: H cycles, all DUT outputs low.
- LOAD: H cycles, config_load=1.
- DONE: done=1 one cycle, busy drops same cycle -> IDLE.
- abort (any non-IDLE state):
  - Next cycle IDLE; config_clk, config_in and config_load forced 0.
  - No done pulse; aborted=1; partial readback word discarded.
  - abort has priority over a simultaneous start.
- All DUT-side outputs are registered (IOB-friendly) with no combinational paths from inputs.

Decomposition:
- Package cfg_shift_pkg: FSM state enum; H_MIN=4 constant; word-index/bit-index helper widths.
- One natural sub-module: sync_2ff (2-flop synchronizer for config_out, async reset to 0), reusable for scan_out and dnn_output inputs.

Test Plan:
- n_bits=8, clk_div=4, load_en=1, src word0=0x000000A5:
  - config_in bits 1,0,1,0,0,1,0,1 (LSB first); 8 rising config_clk edges, period 8 cycles.
  - 4-cycle low gap, then config_load high 4 cycles, then done.
  - busy high throughout.
- Loopback: config_out driven as config_in delayed by one config_clk period, n_bits=32, word0=0xDEADBEEF -> rb word0 = 0xDEADBEEF<<1 with bit0 = initial chain value (0); single rb_we at rb_addr 0.
- n_bits=40, word0=0xFFFFFFFF, word1=0x000000AA:
  - Two FETCH bursts; rb_we at addr 0 then addr 1.
  - rb word1 has bits 31:8 = 0.
  - bit_cnt=40 at done.
- clk_div=0 then clk_div=1 -> each half-period measures 4 cycles; clk_div=10 -> 10 cycles.
- abort asserted during the 5th SHIFT_HI of a 16-bit transfer:
  - Next cycle config_clk=0, busy=0, aborted=1.
  - No done; no rb_we; next start clears aborted.
- Corner cases:
  - n_bits=0 -> done after 1 busy cycle, zero config_clk edges.
  - start pulsed mid-transfer -> ignored.
  - n_bits=2000 -> clamped to 1024 shifts.
  - Reset asserted mid-SHIFT_HI -> all outputs 0 immediately.

Source files
------------

// File: rtl/cfg_shift_pkg.sv
// Shared types and constants for the configuration-chain sequencer.
package cfg_shift_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_FLUSH,
    ST_LOAD_SETUP,
    ST_LOAD,
    ST_DONE
  } state_t;

  // Floor on the config_clk half-period so a readback bit clears the 2-flop synchronizer.
  localparam logic [7:0] H_MIN = 8'd4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cfg_shift_ctrl.sv
// Config-chain sequencer: streams buffer words LSB-first into the DUT chain,
// captures synchronized readback into the readback buffer, optionally pulses config_load.
module cfg_shift_ctrl
  import cfg_shift_pkg::*;
#(
  parameter int CFG_BITS = 1024,
  parameter int WORD_W   = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        clk_div,
  input  logic [15:0]       n_bits,
  input  logic              load_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [WORD_W-1:0] src_data,
  output logic              rb_we,
  output logic [ADDR_W-1:0] rb_addr,
  output logic [WORD_W-1:0] rb_data,
  output logic              config_clk,
  output logic              config_in,
  output logic              config_load,
  input  logic              config_out,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [15:0]       bit_cnt
);

  localparam int         BIT_W = idx_w(WORD_W);
  localparam logic [15:0] N_MAX = 16'(CFG_BITS);

  state_t            state, state_nxt;
  logic [7:0]        h_eff, h_lat, tmr;
  logic [15:0]       n_eff, n_lat;
  logic              ld_lat, fetch_ph;
  logic [WORD_W-1:0] sreg, rb_word, rb_word_nxt;
  logic [BIT_W-1:0]  bit_idx;
  logic              cfg_out_s, cfg_in_nxt;
  logic              tmr_end, last_bit, word_end, busy_st, accept, shift_done;

  sync_2ff u_sync_cfg_out (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .d     (config_out),
    .q     (cfg_out_s)
  );

  assign h_eff      = (clk_div < H_MIN) ? H_MIN : clk_div;
  assign n_eff      = (n_bits > N_MAX) ? N_MAX : n_bits;
  assign bit_idx    = bit_cnt[BIT_W-1:0];
  assign tmr_end    = (tmr == 8'd0);
  assign last_bit   = ((bit_cnt + 16'd1) == n_lat);
  assign word_end   = (bit_idx == BIT_W'(WORD_W - 1));
  assign busy_st    = (state != ST_IDLE) && (state != ST_DONE);
  assign accept     = (state == ST_IDLE) && start && !abort;
  assign shift_done = (state == ST_SHIFT_HI) && tmr_end && (state_nxt != ST_IDLE);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state <= ST_IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (accept) state_nxt = (n_eff == 16'd0) ? ST_FLUSH : ST_FETCH;
      ST_FETCH:      if (fetch_ph) state_nxt = ST_SHIFT_LO;
      ST_SHIFT_LO:   if (tmr_end) state_nxt = ST_SHIFT_HI;
      ST_SHIFT_HI: begin
        if (tmr_end) begin
          if (last_bit)      state_nxt = ST_FLUSH;
          else if (word_end) state_nxt = ST_FETCH;
          else               state_nxt = ST_SHIFT_LO;
        end
      end
      // A zero-length transfer never pulses config_load.
      ST_FLUSH:      state_nxt = (ld_lat && (n_lat != 16'd0)) ? ST_LOAD_SETUP : ST_DONE;
      ST_LOAD_SETUP: if (tmr_end) state_nxt = ST_LOAD;
      ST_LOAD:       if (tmr_end) state_nxt = ST_DONE;
      ST_DONE:       state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
    if (abort && busy_st) state_nxt = ST_IDLE;
  end

  always_comb begin
    rb_word_nxt          = rb_word;
    rb_word_nxt[bit_idx] = cfg_out_s;
  end

  // config_in is set on entry to SHIFT_LO and held through SHIFT_HI so it is stable at the rising edge.
  always_comb begin
    cfg_in_nxt = 1'b0;
    if ((state_nxt == ST_SHIFT_LO) || (state_nxt == ST_SHIFT_HI)) begin
      if (state == ST_FETCH)
        cfg_in_nxt = src_data[0];
      else if ((state == ST_SHIFT_HI) && (state_nxt == ST_SHIFT_LO))
        cfg_in_nxt = sreg[1];
      else
        cfg_in_nxt = config_in;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      h_lat       <= 8'd0;
      n_lat       <= 16'd0;
      ld_lat      <= 1'b0;
      tmr         <= 8'd0;
      fetch_ph    <= 1'b0;
      sreg        <= '0;
      rb_word     <= '0;
      src_addr    <= '0;
      rb_we       <= 1'b0;
      rb_addr     <= '0;
      rb_data     <= '0;
      config_clk  <= 1'b0;
      config_in   <= 1'b0;
      config_load <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      bit_cnt     <= 16'd0;
    end else begin
      if (state_nxt != state) tmr <= h_lat - 8'd1;
      else if (!tmr_end)      tmr <= tmr - 8'd1;

      fetch_ph <= (state == ST_FETCH) && (state_nxt == ST_FETCH);

      if (accept) begin
        h_lat    <= h_eff;
        n_lat    <= n_eff;
        ld_lat   <= load_en;
        bit_cnt  <= 16'd0;
        aborted  <= 1'b0;
        src_addr <= '0;
        rb_word  <= '0;
      end
      if (abort && busy_st) aborted <= 1'b1;

      if ((state == ST_FETCH) && fetch_ph) sreg <= src_data;

      if (shift_done) begin
        bit_cnt <= bit_cnt + 16'd1;
        sreg    <= sreg >> 1;
        rb_word <= (last_bit || word_end) ? '0 : rb_word_nxt;
        if (word_end && !last_bit) src_addr <= src_addr + ADDR_W'(1);
      end

      // Word flushes on a word boundary or the final bit; upper bits of a partial word stay zero.
      rb_we <= shift_done && (last_bit || word_end);
      if (shift_done && (last_bit || word_end)) begin
        rb_addr <= src_addr;
        rb_data <= rb_word_nxt;
      end

      config_clk  <= (state_nxt == ST_SHIFT_HI);
      config_in   <= cfg_in_nxt;
      config_load <= (state_nxt == ST_LOAD);
      busy        <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
      done        <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_cfg_shift_ctrl.sv
// Directed bench for cfg_shift_ctrl: vector table plus hand sequences for abort, restart and reset.
module tb_cfg_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, load_en;
  logic [7:0]  clk_div;
  logic [15:0] n_bits;
  logic [4:0]  src_addr, rb_addr;
  logic [31:0] src_data, rb_data;
  logic        rb_we, config_clk, config_in, config_load, config_out;
  logic        busy, done, aborted;
  logic [15:0] bit_cnt;

  logic [31:0] mem [32];
  logic        mclr, chain_clr;
  logic        c0, c1;

  // Monitor state
  int          edges, hi_run, hi_min, hi_max, lo_run, gap;
  int          we_cnt, last_addr, busy_cnt, done_cnt, load_cnt, viol;
  logic        pclk, pload;
  logic [63:0] stream;
  logic [31:0] rbmem [32];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cfg_shift_ctrl dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .start         (start),
    .abort         (abort),
    .clk_div       (clk_div),
    .n_bits        (n_bits),
    .load_en       (load_en),
    .src_addr      (src_addr),
    .src_data      (src_data),
    .rb_we         (rb_we),
    .rb_addr       (rb_addr),
    .rb_data       (rb_data),
    .config_clk    (config_clk),
    .config_in     (config_in),
    .config_load   (config_load),
    .config_out    (config_out),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .bit_cnt       (bit_cnt)
  );

  always @(posedge clk) src_data <= mem[src_addr];

  // Two-stage chain: config_out shows the bit shifted in one config_clk period earlier.
  always @(posedge config_clk or posedge chain_clr) begin
    if (chain_clr) begin
      c0 <= 1'b0;
      c1 <= 1'b0;
    end else begin
      c0 <= config_in;
      c1 <= c0;
    end
  end
  assign config_out = c1;

  always @(negedge clk) begin
    if (mclr) begin
      edges <= 0; hi_run <= 0; hi_min <= 999; hi_max <= 0; lo_run <= 0; gap <= 0;
      we_cnt <= 0; last_addr <= 0; busy_cnt <= 0; done_cnt <= 0; load_cnt <= 0; viol <= 0;
      pclk <= 1'b0; pload <= 1'b0; stream <= '0;
      for (int i = 0; i < 32; i++) rbmem[i] <= '0;
    end else begin
      pclk  <= config_clk;
      pload <= config_load;
      if (config_clk && !pclk) begin
        if (edges < 64) stream[edges] <= config_in;
        edges <= edges + 1;
      end
      if (config_clk) begin
        hi_run <= hi_run + 1;
        lo_run <= 0;
      end else begin
        if (pclk) begin
          if (hi_run < hi_min) hi_min <= hi_run;
          if (hi_run > hi_max) hi_max <= hi_run;
        end
        hi_run <= 0;
        lo_run <= lo_run + 1;
      end
      if (config_load && !pload) gap <= lo_run;
      if (rb_we) begin
        rbmem[rb_addr] <= rb_data;
        we_cnt         <= we_cnt + 1;
        last_addr      <= int'(rb_addr);
      end
      if (busy) busy_cnt <= busy_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (config_load) load_cnt <= load_cnt + 1;
      if (config_load && (config_clk || config_in)) viol <= viol + 1;
    end
  end

  typedef struct {
    logic [7:0]  div;
    logic [15:0] n;
    logic        ld;
    logic [31:0] w0, w1;
    int          e_edges, e_hi;
    logic [31:0] e_stream, e_rb0, e_rb1;
    int          e_we, e_last, e_bc, e_load, e_gap, e_busy;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk); #1; mclr = 1'b1; chain_clr = 1'b1;
    @(posedge clk); #1; mclr = 1'b0; chain_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic wait_edges(input string name, input int target);
    for (int k = 0; k < 1000 && edges < target; k++) begin
      @(negedge clk); #1;
    end
    chk(name, 64'(edges), 64'(target));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d_", idx);
    for (int i = 0; i < 32; i++) mem[i] = (i == 0) ? v.w0 : (i == 1) ? v.w1 : 32'h0;
    clk_div = v.div;
    n_bits  = v.n;
    load_en = v.ld;
    clear_mon();
    pulse_start();
    wait_done({p, "done_seen"}, 20000);
    chk({p, "edges"},   64'(edges),    64'(v.e_edges));
    chk({p, "stream"},  stream[31:0],  v.e_stream);
    if (v.e_hi != 0) begin
      chk({p, "hi_min"}, 64'(hi_min), 64'(v.e_hi));
      chk({p, "hi_max"}, 64'(hi_max), 64'(v.e_hi));
    end
    chk({p, "rb_we_cnt"}, 64'(we_cnt), 64'(v.e_we));
    if (v.e_we >= 1) begin
      chk({p, "rb_word0"},  rbmem[0], v.e_rb0);
      chk({p, "rb_last_addr"}, 64'(last_addr), 64'(v.e_last));
    end
    if (v.e_we >= 2) chk({p, "rb_word1"}, rbmem[1], v.e_rb1);
    chk({p, "bit_cnt"},   bit_cnt,        64'(v.e_bc));
    chk({p, "load_cyc"},  64'(load_cnt),  64'(v.e_load));
    chk({p, "load_gap"},  64'(gap),       64'(v.e_gap));
    chk({p, "busy_cyc"},  64'(busy_cnt),  64'(v.e_busy));
    chk({p, "done_cnt"},  64'(done_cnt),  64'd1);
    chk({p, "load_viol"}, 64'(viol),      64'd0);
    chk({p, "aborted"},   64'(aborted),   64'd0);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_rb_data"}, rb_data, 64'd0);
    chk({name, "_ctl"}, {src_addr, rb_we, rb_addr, config_clk, config_in, config_load,
                         busy, done, aborted, bit_cnt}, 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; load_en = 1'b0;
    clk_div = 8'd4; n_bits = 16'd0; mclr = 1'b0; chain_clr = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    //          div   n       ld  w0            w1            edges hi  stream        rb0           rb1           we last bc    load gap busy
    vecs[0] = '{8'd4,  16'd8,    1, 32'h000000A5, 32'h0,        8,    4,  32'h000000A5, 32'h0000004A, 32'h0,        1, 0,  8,    4,   5,  75};
    vecs[1] = '{8'd4,  16'd32,   0, 32'hDEADBEEF, 32'h0,        32,   4,  32'hDEADBEEF, 32'hBD5B7DDE, 32'h0,        1, 0,  32,   0,   0,  259};
    vecs[2] = '{8'd4,  16'd40,   0, 32'hFFFFFFFF, 32'h000000AA, 40,   4,  32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000055, 2, 1,  40,   0,   0,  325};
    vecs[3] = '{8'd0,  16'd4,    0, 32'h00000005, 32'h0,        4,    4,  32'h00000005, 32'h0000000A, 32'h0,        1, 0,  4,    0,   0,  35};
    vecs[4] = '{8'd1,  16'd4,    1, 32'h00000003, 32'h0,        4,    4,  32'h00000003, 32'h00000006, 32'h0,        1, 0,  4,    4,   5,  43};
    vecs[5] = '{8'd10, 16'd3,    1, 32'h00000006, 32'h0,        3,    10, 32'h00000006, 32'h00000004, 32'h0,        1, 0,  3,    10,  11, 83};
    vecs[6] = '{8'd4,  16'd0,    1, 32'h12345678, 32'h0,        0,    0,  32'h00000000, 32'h0,        32'h0,        0, 0,  0,    0,   0,  1};
    vecs[7] = '{8'd4,  16'd2000, 0, 32'h12345678, 32'h0F0F0F0F, 1024, 4,  32'h12345678, 32'h2468ACF0, 32'h1E1E1E1E, 32, 31, 1024, 0,   0,  8257};

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // start while busy is ignored, as are mid-transfer n_bits/clk_div changes
    mem[0] = 32'h000000A5; clk_div = 8'd4; n_bits = 16'd8; load_en = 1'b0;
    clear_mon();
    pulse_start();
    repeat (20) @(posedge clk);
    #1; n_bits = 16'd3; clk_div = 8'd10; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done("restart_done_seen", 2000);
    chk("restart_edges",    64'(edges),    64'd8);
    chk("restart_bit_cnt",  bit_cnt,       64'd8);
    chk("restart_hi_max",   64'(hi_max),   64'd4);
    chk("restart_done_cnt", 64'(done_cnt), 64'd1);
    chk("restart_busy_cyc", 64'(busy_cnt), 64'd67);

    // abort during the 5th SHIFT_HI of a 16-bit transfer
    mem[0] = 32'h0000FFFF; clk_div = 8'd4; n_bits = 16'd16; load_en = 1'b1;
    clear_mon();
    pulse_start();
    wait_edges("abort_edge_wait", 5);
    @(posedge clk); #1;
    chk("abort_pre_clk", 64'(config_clk), 64'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_clk",     64'(config_clk), 64'd0);
    chk("abort_in",      64'(config_in),  64'd0);
    chk("abort_busy",    64'(busy),       64'd0);
    chk("abort_flag",    64'(aborted),    64'd1);
    repeat (10) @(negedge clk);
    #1;
    chk("abort_done_cnt", 64'(done_cnt), 64'd0);
    chk("abort_rb_we",    64'(we_cnt),   64'd0);
    chk("abort_load",     64'(load_cnt), 64'd0);

    // abort beats a simultaneous start in IDLE; aborted stays sticky
    n_bits = 16'd0;
    @(posedge clk); #1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    chk("prio_busy",    64'(busy),    64'd0);
    chk("prio_aborted", 64'(aborted), 64'd1);
    pulse_start();
    chk("restart_clears_aborted", 64'(aborted), 64'd0);
    chk("restart_busy",           64'(busy),    64'd1);
    wait_done("n0_after_abort_done", 100);

    // asynchronous reset in the middle of SHIFT_HI
    mem[0] = 32'h0000FFFF; clk_div = 8'd4; n_bits = 16'd16; load_en = 1'b0;
    clear_mon();
    pulse_start();
    wait_edges("rst_edge_wait", 2);
    chk("rst_pre_clk",  64'(config_clk), 64'd1);
    chk("rst_pre_busy", 64'(busy),       64'd1);
    #2; rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
